// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: D_out = A - B - B_in, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag on port OVF.
module serial_ripple_subtractor #(
   parameter int n = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic         B_in,
   output logic [n-1:0] D_out,
   output logic         B_out,
   output logic         busy,
`ifdef SERIAL_SUB_OVF_EN
   output logic         OVF,
`endif
   output logic         done
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [n-1:0]    a_q, a_d, b_q, b_d;
   logic [n-2:0]    d_q, d_d;
   logic            bor_q, bor_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [n-1:0]    dout_q, dout_d;
   logic            bout_q, bout_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic            d_bit, bor_nxt, last;
   logic [n-1:0]    d_full;

   assign last    = (cnt_q == LAST);
   assign d_bit   = a_q[0] ^ b_q[0] ^ bor_q;
   assign bor_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
   // Difference bits gathered so far with the current bit on top; equals the full result on the last step.
   assign d_full  = {d_bit, d_q};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;  else state_d = IDLE;
         RUN:     if (last)  state_d = DONE; else state_d = RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture in IDLE, shift one bit per RUN cycle
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      d_d   = d_q;
      bor_d = bor_q;
      cnt_d = cnt_q;
      if (state_q == IDLE && start) begin
         a_d   = A;
         b_d   = B;
         d_d   = {(n-1){1'b0}};
         bor_d = B_in;
         cnt_d = {CW{1'b0}};
      end else if (state_q == RUN) begin
         a_d   = {1'b0, a_q[n-1:1]};
         b_d   = {1'b0, b_q[n-1:1]};
         d_d   = d_full[n-1:1];
         bor_d = bor_nxt;
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output logic: results load only on the final RUN step
   always_comb begin
      dout_d = dout_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      if (state_q == RUN && last) begin
         dout_d = d_full;
         bout_d = bor_nxt;
         // a_q[0]/b_q[0] hold the operand sign bits at this point.
         ovf_d  = (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= {n{1'b0}};
         b_q    <= {n{1'b0}};
         d_q    <= {(n-1){1'b0}};
         bor_q  <= 1'b0;
         cnt_q  <= {CW{1'b0}};
         dout_q <= {n{1'b0}};
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         d_q    <= d_d;
         bor_q  <= bor_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign D_out = dout_q;
   assign B_out = bout_q;
   assign busy  = busy_q;
   assign done  = done_q;
`ifdef SERIAL_SUB_OVF_EN
   assign OVF   = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor (n=5); also checks OVF when SERIAL_SUB_OVF_EN is defined.
module tb_serial_ripple_subtractor;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] A, B;
   logic         B_in;
   logic [N-1:0] D_out;
   logic         B_out, busy, done;
`ifdef SERIAL_SUB_OVF_EN
   logic         OVF;
`endif

   serial_ripple_subtractor #(.n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .B_in(B_in),
      .D_out(D_out), .B_out(B_out), .busy(busy),
`ifdef SERIAL_SUB_OVF_EN
      .OVF(OVF),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [N+1:0] sb_q[$];          // {ovf, borrow, difference}
   bit  b2b_mode = 1'b0;
   bit  prev_valid = 1'b0;
   int  prev_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
      logic [N:0] full;
      logic       ovf;
      full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
      ovf  = (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
      return {ovf, full[N], full[N-1:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare every done pulse with the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [N+1:0] e;
            e = sb_q.pop_front();
            chk("D_out", 32'(D_out), 32'(e[N-1:0]));
            chk("B_out", 32'(B_out), 32'(e[N]));
`ifdef SERIAL_SUB_OVF_EN
            chk("OVF", 32'(OVF), 32'(e[N+1]));
`endif
         end
         if (b2b_mode && prev_valid) chk("b2b_spacing", 32'(cyc - prev_cyc), 32'(N + 2));
         prev_valid = 1'b1;
         prev_cyc   = cyc;
      end
   end

   // Start one operation from IDLE, optionally disturbing inputs mid-run, and check latency/busy.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, input bit disturb);
      int k;
      bit seen;
      @(negedge clk);
      A = a; B = b; B_in = bi; start = 1'b1;
      sb_q.push_back(model(a, b, bi));
      @(posedge clk);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 3 * N) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            chk("busy_run", 32'(busy), 32'd1);
         end
         if (disturb && k == 1) begin
            start = 1'b1; A = ~a; B = a ^ b; B_in = ~bi;
         end
         if (disturb && k == 2) start = 1'b0;
         @(posedge clk);
         k++;
         #1;
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      else chk("latency", 32'(k), 32'(N));
      @(negedge clk);
      chk("busy_done", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_single", 32'(done), 32'd0);
      if (disturb) begin
         // No further done may follow the ignored start pulse.
         repeat (N + 3) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done), 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_D_out", 32'(D_out), 32'd0);
      chk("rst_B_out", 32'(B_out), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_OVF",   32'(OVF),   32'd0);
`endif
      rst = 1'b0;

      run_op(5'd15, 5'd5,  1'b1, 1'b0);
      run_op(5'd5,  5'd15, 1'b0, 1'b0);
      run_op(5'd31, 5'd31, 1'b0, 1'b0);
      run_op(5'd0,  5'd0,  1'b1, 1'b0);
      run_op(5'b01111, 5'b10000, 1'b0, 1'b0);
      run_op(5'd3,  5'd1,  1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         run_op(N'($urandom_range(31)), N'($urandom_range(31)), 1'($urandom_range(1)), 1'b0);

      // Start ignored during RUN, operand changes do not disturb the result.
      run_op(5'd22, 5'd9, 1'b1, 1'b1);

      // Reset at the third RUN cycle: outputs clear at once, no done.
      @(negedge clk);
      A = 5'd17; B = 5'd4; B_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_D_out", 32'(D_out), 32'd0);
      chk("rst_mid_B_out", 32'(B_out), 32'd0);
      chk("rst_mid_busy",  32'(busy),  32'd0);
      chk("rst_mid_done",  32'(done),  32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (N + 2) begin
         @(negedge clk);
         chk("aborted_no_done", 32'(done), 32'd0);
      end
      run_op(5'd20, 5'd7, 1'b0, 1'b0);

      // Back-to-back with start held high.
      b2b_mode = 1'b1; prev_valid = 1'b0;
      @(negedge clk);
      A = 5'd25; B = 5'd6; B_in = 1'b0; start = 1'b1;
      sb_q.push_back(model(5'd25, 5'd6, 1'b0));
      @(posedge clk);
      @(negedge clk);
      A = 5'd4; B = 5'd19; B_in = 1'b1;
      sb_q.push_back(model(5'd4, 5'd19, 1'b1));
      repeat (N + 2) @(posedge clk);
      @(negedge clk);
      A = 5'd30; B = 5'd12; B_in = 1'b1;
      sb_q.push_back(model(5'd30, 5'd12, 1'b1));
      repeat (N + 2) @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (2 * N) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
